// File: rtl/load_store_unit.sv
// Load/store unit between the CPU data port and the registered-read data Memory.
// Handles one request at a time, with alignment/range checks and load extension.
module load_store_unit #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_width,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_write,
  output logic        resp_fault,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [3:0]  mem_width_q, mem_width_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_write_q, resp_write_d;
  logic        resp_fault_q, resp_fault_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        write_q, write_d;

  logic        accept;
  logic [3:0]  req_width;
  logic        funct3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_fault;
  logic [31:0] load_ext;

  assign req_ready = (state_q == IDLE) || (state_q == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_width = 4'd0;
    case (req_funct3[1:0])
      2'd0:    req_width = 4'd1;
      2'd1:    req_width = 4'd2;
      2'd2:    req_width = 4'd4;
      default: req_width = 4'd0;
    endcase
    if (req_write) funct3_ok = (req_funct3 < 3'd3);
    else           funct3_ok = (req_funct3 != 3'd3) && (req_funct3 < 3'd6);
    misaligned   = ((req_width == 4'd2) && req_address[0]) ||
                   ((req_width == 4'd4) && (req_address[1:0] != 2'b00));
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    out_of_range = ({1'b0, req_address} + {29'd0, req_width}) > 33'(MEM_SIZE);
    req_fault    = !funct3_ok || misaligned || out_of_range;
  end

  always_comb begin
    load_ext = mem_rdata;
    case (funct3_q)
      3'd0:    load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    load_ext = {24'd0, mem_rdata[7:0]};
      3'd5:    load_ext = {16'd0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_width_d   = 4'd0;
    mem_write_d   = 1'b0;
    mem_wdata_d   = mem_wdata_q;
    resp_valid_d  = 1'b0;
    resp_write_d  = resp_write_q;
    resp_fault_d  = resp_fault_q;
    resp_rd_d     = resp_rd_q;
    resp_data_d   = resp_data_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    write_d       = write_q;

    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          funct3_d      = req_funct3;
          rd_d          = req_rd;
          write_d       = req_write;
          mem_address_d = req_address;
          if (req_fault) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_write_d = 1'b0;
            resp_fault_d = 1'b1;
            resp_rd_d    = 5'd0;
            resp_data_d  = 32'd0;
          end else begin
            state_d     = ISSUE;
            mem_width_d = req_width;
            mem_write_d = req_write;
            if (req_write) mem_wdata_d = req_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_write_d = 1'b1;
          resp_fault_d = 1'b0;
          resp_rd_d    = 5'd0;
          resp_data_d  = 32'd0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_write_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rd_d    = rd_q;
        resp_data_d  = load_ext;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_address_q <= 32'd0;
      mem_width_q   <= 4'd0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= 32'd0;
      resp_valid_q  <= 1'b0;
      resp_write_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_rd_q     <= 5'd0;
      resp_data_q   <= 32'd0;
      funct3_q      <= 3'd0;
      rd_q          <= 5'd0;
      write_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_width_q   <= mem_width_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_write_q  <= resp_write_d;
      resp_fault_q  <= resp_fault_d;
      resp_rd_q     <= resp_rd_d;
      resp_data_q   <= resp_data_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      write_q       <= write_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_width   = mem_width_q;
  assign mem_write   = mem_write_q;
  assign mem_wdata   = mem_wdata_q;
  assign resp_valid  = resp_valid_q;
  assign resp_write  = resp_write_q;
  assign resp_fault  = resp_fault_q;
  assign resp_rd     = resp_rd_q;
  assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed Memory model, directed vector table,
// plus hand-written back-to-back and reset-mid-operation sequences.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_address;
  logic [3:0]  mem_width;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_write;
  logic        resp_fault;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] memBytes [0:1023];

  always #5 clock = ~clock;

  load_store_unit #(.MEM_SIZE(1024)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_address(mem_address), .mem_width(mem_width), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_write(resp_write), .resp_fault(resp_fault),
    .resp_rd(resp_rd), .resp_data(resp_data)
  );

  // Registered-read Memory: low bytes of data_out, zero-filled, one clock after sampling
  always @(posedge clock) begin
    if (mem_width != 4'd0) begin
      if (mem_write) begin
        for (int i = 0; i < 4; i++)
          if (i < int'(mem_width)) memBytes[mem_address[9:0] + 10'(i)] <= mem_wdata[8*i +: 8];
      end else begin
        logic [31:0] rd;
        rd = 32'd0;
        for (int i = 0; i < 4; i++)
          if (i < int'(mem_width)) rd[8*i +: 8] = memBytes[mem_address[9:0] + 10'(i)];
        mem_rdata <= rd;
      end
    end
  end

  typedef struct {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        expFault;
    logic [31:0] expData;
    logic [4:0]  expRd;
    int          expLatency;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkLoad(input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [4:0] rd, input logic [31:0] expData);
    vec_t v;
    v = '{write: 1'b0, funct3: f3, address: addr, wdata: 32'd0, rd: rd,
          expFault: 1'b0, expData: expData, expRd: rd, expLatency: 3};
    return v;
  endfunction

  function automatic vec_t mkStore(input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata);
    vec_t v;
    v = '{write: 1'b1, funct3: f3, address: addr, wdata: wdata, rd: 5'd9,
          expFault: 1'b0, expData: 32'd0, expRd: 5'd0, expLatency: 2};
    return v;
  endfunction

  function automatic vec_t mkFault(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    vec_t v;
    v = '{write: wr, funct3: f3, address: addr, wdata: 32'hDEAD_BEEF, rd: 5'd11,
          expFault: 1'b1, expData: 32'd0, expRd: 5'd0, expLatency: 1};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one request until accepted, then follows it to its completion pulse
  task automatic applyStimulus(input vec_t v, output int latency, output logic sawMem);
    int guard;
    @(negedge clock);
    req_write   = v.write;
    req_funct3  = v.funct3;
    req_address = v.address;
    req_wdata   = v.wdata;
    req_rd      = v.rd;
    req_valid   = 1'b1;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    latency = 1;
    sawMem = (mem_width != 4'd0) || mem_write;
    while (!resp_valid && latency < 8) begin
      @(posedge clock);
      #1;
      latency++;
      sawMem = sawMem || (mem_width != 4'd0) || mem_write;
    end
  endtask

  initial begin
    int lat;
    logic sawMem;
    logic [31:0] rdCol [1:7];
    logic [4:0]  rdReg [1:7];
    logic        validCol [1:7];

    for (int i = 0; i < 1024; i++) memBytes[i] = 8'h00;
    memBytes[16] = 8'hA5; memBytes[17] = 8'hF0; memBytes[18] = 8'h01; memBytes[19] = 8'h80;
    mem_rdata = 32'd0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_address = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset mem_width", 32'(mem_width), 32'd0);
    checkOutput("reset mem_write", 32'(mem_write), 32'd0);
    checkOutput("reset mem_address", mem_address, 32'd0);
    checkOutput("reset resp_data", resp_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    vecs.push_back(mkLoad(3'd0, 32'h10, 5'd1, 32'hFFFF_FFA5));
    vecs.push_back(mkLoad(3'd4, 32'h10, 5'd2, 32'h0000_00A5));
    vecs.push_back(mkLoad(3'd1, 32'h10, 5'd3, 32'hFFFF_F0A5));
    vecs.push_back(mkLoad(3'd5, 32'h10, 5'd4, 32'h0000_F0A5));
    vecs.push_back(mkLoad(3'd2, 32'h10, 5'd5, 32'h8001_F0A5));
    vecs.push_back(mkLoad(3'd0, 32'h13, 5'd6, 32'hFFFF_FF80));
    vecs.push_back(mkLoad(3'd4, 32'h12, 5'd7, 32'h0000_0001));
    vecs.push_back(mkStore(3'd2, 32'h20, 32'h1234_5678));
    vecs.push_back(mkLoad(3'd2, 32'h20, 5'd6, 32'h1234_5678));
    vecs.push_back(mkStore(3'd0, 32'h30, 32'h7777_77EF));
    vecs.push_back(mkLoad(3'd2, 32'h30, 5'd8, 32'h0000_00EF));
    vecs.push_back(mkStore(3'd1, 32'h32, 32'h5555_8123));
    vecs.push_back(mkLoad(3'd1, 32'h32, 5'd9, 32'hFFFF_8123));
    vecs.push_back(mkFault(1'b0, 3'd1, 32'h21));
    vecs.push_back(mkFault(1'b0, 3'd2, 32'h22));
    vecs.push_back(mkFault(1'b1, 3'd2, 32'h3FE));
    vecs.push_back(mkFault(1'b0, 3'd0, 32'h400));
    vecs.push_back(mkFault(1'b0, 3'd3, 32'h10));
    vecs.push_back(mkFault(1'b1, 3'd4, 32'h10));
    vecs.push_back(mkStore(3'd2, 32'h3FC, 32'hCAFE_BABE));
    vecs.push_back(mkLoad(3'd2, 32'h3FC, 5'd10, 32'hCAFE_BABE));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], lat, sawMem);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLatency));
      checkOutput($sformatf("v%0d resp_fault", i), 32'(resp_fault), 32'(vecs[i].expFault));
      checkOutput($sformatf("v%0d resp_rd", i), 32'(resp_rd), 32'(vecs[i].expRd));
      checkOutput($sformatf("v%0d resp_data", i), resp_data, vecs[i].expData);
      checkOutput($sformatf("v%0d mem access", i), 32'(sawMem), 32'(!vecs[i].expFault));
      if (!vecs[i].expFault)
        checkOutput($sformatf("v%0d resp_write", i), 32'(resp_write), 32'(vecs[i].write));
    end

    // Back-to-back loads: second request held on req_valid, accepted in the first RESP cycle
    @(negedge clock);
    req_write = 1'b0; req_funct3 = 3'd2; req_address = 32'h10; req_rd = 5'd12;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_address = 32'h20; req_rd = 5'd13;
    for (int k = 2; k <= 7; k++) begin
      @(posedge clock);
      #1;
      validCol[k] = resp_valid;
      rdCol[k] = resp_data;
      rdReg[k] = resp_rd;
      if (k == 4) req_valid = 1'b0;
    end
    checkOutput("b2b first valid", 32'(validCol[3]), 32'd1);
    checkOutput("b2b first data", rdCol[3], 32'h8001_F0A5);
    checkOutput("b2b first rd", 32'(rdReg[3]), 32'd12);
    checkOutput("b2b gap valid", 32'({validCol[2], validCol[4], validCol[5], validCol[7]}), 32'd0);
    checkOutput("b2b second valid", 32'(validCol[6]), 32'd1);
    checkOutput("b2b second data", rdCol[6], 32'h1234_5678);
    checkOutput("b2b second rd", 32'(rdReg[6]), 32'd13);

    // Reset in the CAPTURE cycle of a load discards the response
    @(negedge clock);
    req_write = 1'b0; req_funct3 = 3'd2; req_address = 32'h10; req_rd = 5'd14;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst capture resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst capture req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst capture resp_data", resp_data, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("rst after resp_valid", 32'(resp_valid), 32'd0);

    // Reset coinciding with a store's ISSUE edge: Memory still takes the write
    @(negedge clock);
    req_write = 1'b1; req_funct3 = 3'd2; req_address = 32'h40; req_wdata = 32'hA5A5_5A5A;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("rst issue mem_write", 32'(mem_write), 32'd0);
    checkOutput("rst issue resp_valid", 32'(resp_valid), 32'd0);
    applyStimulus(mkLoad(3'd2, 32'h40, 5'd15, 32'hA5A5_5A5A), lat, sawMem);
    checkOutput("rst store readback", resp_data, 32'hA5A5_5A5A);
    checkOutput("rst store latency", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the summary");
    $fatal(1, "[TB] timeout");
  end

endmodule
